// File: rtl/stopwatch_disp_pkg.sv
// Shared segment/anode constants and the digit-index type for the
// stopwatch seven-segment display multiplexer.
package stopwatch_disp_pkg;

    typedef logic [1:0] digit_idx_t;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;
    // idx 0 is the leftmost digit (min1 on an[3]).
    localparam logic [3:0] AN_ONE_COLD [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/stopwatch_display_mux_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; codes 10-15 show a dash.
module seg7_decode
    import stopwatch_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Time-multiplexed 4-digit common-anode driver for the stopwatch counter,
// with per-frame digit snapshots, one dark cycle between slots and field blink.
module stopwatch_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] min1,
    input  logic [3:0] min2,
    input  logic [2:0] sec1,
    input  logic [3:0] sec2,
    input  logic       blink_en,
    input  logic       blink_sel,
    input  logic       dp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    import stopwatch_disp_pkg::*;

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic          scan_tick;
    logic          drive_pending;
    logic          snap_valid;
    digit_idx_t    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [3:0]    shadow [4];
    logic [6:0]    cur_seg;
    logic          blink_hit;

    assign scan_tick = (prescaler == PW'(REFRESH_DIV - 1));
    // Minutes occupy idx 0-1, seconds idx 2-3.
    assign blink_hit = blink_en && blink_phase && (blink_sel ? !idx[1] : idx[1]);

    seg7_decode u_decode (
        .digit (shadow[idx]),
        .seg   (cur_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (scan_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (scan_tick) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            drive_pending <= 1'b0;
            snap_valid    <= 1'b0;
            shadow[0]     <= '0;
            shadow[1]     <= '0;
            shadow[2]     <= '0;
            shadow[3]     <= '0;
            an            <= AN_OFF;
            seg           <= SEG_OFF;
            dp            <= 1'b1;
        end else begin
            drive_pending <= scan_tick;
            if (scan_tick) begin
                // Blank edge: go dark while the index moves, refresh snapshot at frame start.
                idx <= idx + 2'd1;
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
                if (!snap_valid || idx == 2'd3) begin
                    snap_valid <= 1'b1;
                    shadow[0]  <= {1'b0, min1};
                    shadow[1]  <= min2;
                    shadow[2]  <= {1'b0, sec1};
                    shadow[3]  <= sec2;
                end
            end else if (drive_pending) begin
                if (blink_hit) begin
                    an  <= AN_OFF;
                    seg <= SEG_OFF;
                    dp  <= 1'b1;
                end else begin
                    an  <= AN_ONE_COLD[idx];
                    seg <= cur_seg;
                    dp  <= ~(dp_en && idx == 2'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Bench for stopwatch_display_mux: decode/frame vectors, mid-frame input change,
// reset timing, and randomized traffic against an edge-count reference model.
module tb_stopwatch_display_mux;

    localparam int RDIV = 4;
    localparam int BDIV = 2;
    localparam logic [11:0] DARK = 12'hFFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] min1 = '0;
    logic [3:0] min2 = '0;
    logic [2:0] sec1 = '0;
    logic [3:0] sec2 = '0;
    logic       blink_en = 1'b0;
    logic       blink_sel = 1'b0;
    logic       dp_en = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_display_mux #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .min1      (min1),
        .min2      (min2),
        .sec1      (sec1),
        .sec2      (sec2),
        .blink_en  (blink_en),
        .blink_sel (blink_sel),
        .dp_en     (dp_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [3:0] ref_an(input int d);
        return 4'b1111 & ~(4'b1000 >> d);
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Reference model: k counts clock edges since reset release; slot m starts at edge m*RDIV.
    int          k = 0;
    int          slot = 0;
    int          d = 0;
    logic        phase;
    logic [3:0]  snap [4];
    logic [11:0] exp_out = DARK;
    logic        chk_on = 1'b1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k       = 0;
            exp_out = DARK;
        end else begin
            k    = k + 1;
            slot = k / RDIV;
            d    = slot % 4;
            if (k % RDIV == 0) begin
                exp_out = DARK;
                if (slot == 1 || d == 0) begin
                    snap[0] = {1'b0, min1};
                    snap[1] = min2;
                    snap[2] = {1'b0, sec1};
                    snap[3] = sec2;
                end
            end else if (k % RDIV == 1 && k > RDIV) begin
                phase = ((slot / BDIV) % 2) == 1;
                if (blink_en && phase && (blink_sel ? (d < 2) : (d >= 2)))
                    exp_out = DARK;
                else
                    exp_out = {ref_an(d), ref_dec(snap[d]), ~(dp_en && d == 1)};
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) check("model", {an, seg, dp}, exp_out);
    end

    task automatic wait_mod(input int target);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (k % 16 != target && guard < 64);
        n_cmp++;
        if (k % 16 != target) begin
            n_bad++;
            $display("FAIL wait_mod: k=%0d never reached phase %0d", k, target);
        end
    endtask

    task automatic check_startup(input string tag, input logic [11:0] exp5);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            check($sformatf("%s_edge%0d", tag, e), {an, seg, dp}, (e < 5) ? DARK : exp5);
        end
    endtask

    task automatic set_digits(input logic [2:0] a, input logic [3:0] b,
                              input logic [2:0] c, input logic [3:0] e, input logic p);
        min1 = a; min2 = b; sec1 = c; sec2 = e; dp_en = p;
    endtask

    typedef struct {
        logic [2:0] m1;
        logic [3:0] m2;
        logic [2:0] s1;
        logic [3:0] s2;
        logic       dpe;
        logic [6:0] e_m1;
        logic [6:0] e_m2;
        logic [6:0] e_s1;
        logic [6:0] e_s2;
        logic       e_dp;
    } vec_t;

    vec_t       vecs [8];
    logic [6:0] exp_seg [4];

    initial begin
        vecs[0] = '{3'd5, 4'd9,  3'd3, 4'd7,  1'b1, 7'b0010010, 7'b0010000, 7'b0110000, 7'b1111000, 1'b0};
        vecs[1] = '{3'd0, 4'd1,  3'd2, 4'd3,  1'b0, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 1'b1};
        vecs[2] = '{3'd4, 4'd5,  3'd1, 4'd6,  1'b1, 7'b0011001, 7'b0010010, 7'b1111001, 7'b0000010, 1'b0};
        vecs[3] = '{3'd6, 4'd7,  3'd7, 4'd8,  1'b0, 7'b0000010, 7'b1111000, 7'b1111000, 7'b0000000, 1'b1};
        vecs[4] = '{3'd5, 4'd12, 3'd3, 4'd7,  1'b0, 7'b0010010, 7'b0111111, 7'b0110000, 7'b1111000, 1'b1};
        vecs[5] = '{3'd0, 4'd10, 3'd0, 4'd11, 1'b0, 7'b1000000, 7'b0111111, 7'b1000000, 7'b0111111, 1'b1};
        vecs[6] = '{3'd2, 4'd13, 3'd5, 4'd14, 1'b1, 7'b0100100, 7'b0111111, 7'b0010010, 7'b0111111, 1'b0};
        vecs[7] = '{3'd1, 4'd15, 3'd4, 4'd9,  1'b0, 7'b1111001, 7'b0111111, 7'b0011001, 7'b0010000, 1'b1};

        // Reset held, then released at a falling edge.
        set_digits(3'd5, 4'd9, 3'd3, 4'd7, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", {an, seg, dp}, DARK);
        end
        reset = 1'b0;
        check_startup("startup", {4'b1011, 7'b0010000, 1'b0});

        // Full-frame vectors: each digit slot, plus the dark gap after slot 0.
        for (int v = 0; v < 8; v++) begin
            set_digits(vecs[v].m1, vecs[v].m2, vecs[v].s1, vecs[v].s2, vecs[v].dpe);
            exp_seg[0] = vecs[v].e_m1;
            exp_seg[1] = vecs[v].e_m2;
            exp_seg[2] = vecs[v].e_s1;
            exp_seg[3] = vecs[v].e_s2;
            wait_mod(0);
            for (int s = 0; s < 4; s++) begin
                wait_mod(4 * s + 2);
                check($sformatf("vec%0d_digit%0d", v, s), {an, seg, dp},
                      {ref_an(s), exp_seg[s], (s == 1) ? vecs[v].e_dp : 1'b1});
                if (s == 0) begin
                    wait_mod(4);
                    check($sformatf("vec%0d_gap", v), {an, seg, dp}, DARK);
                end
            end
        end

        // Inputs change while min2 is lit; rest of the frame keeps the old snapshot.
        set_digits(3'd5, 4'd9, 3'd3, 4'd7, 1'b0);
        wait_mod(0);
        wait_mod(6);
        set_digits(3'd0, 4'd0, 3'd0, 4'd1, 1'b0);
        wait_mod(10);
        check("midframe_sec1_old", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b1});
        wait_mod(14);
        check("midframe_sec2_old", {an, seg, dp}, {4'b1110, 7'b1111000, 1'b1});
        wait_mod(2);
        check("newframe_min1", {an, seg, dp}, {4'b0111, 7'b1000000, 1'b1});
        wait_mod(6);
        check("newframe_min2", {an, seg, dp}, {4'b1011, 7'b1000000, 1'b1});
        wait_mod(10);
        check("newframe_sec1", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
        wait_mod(14);
        check("newframe_sec2", {an, seg, dp}, {4'b1110, 7'b1111001, 1'b1});

        // Randomized traffic with blink; the model checks every cycle.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                min1 = 3'($urandom_range(0, 7));
                min2 = 4'($urandom_range(0, 15));
                sec1 = 3'($urandom_range(0, 7));
                sec2 = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 40) == 0) begin
                blink_en  = ($urandom_range(0, 3) != 0);
                blink_sel = 1'($urandom_range(0, 1));
                dp_en     = 1'($urandom_range(0, 1));
            end
        end

        // Reset pulse in the middle of a lit slot.
        blink_en = 1'b0;
        set_digits(3'd5, 4'd9, 3'd3, 4'd7, 1'b0);
        wait_mod(6);
        #2 reset = 1'b1;
        #1 check("async_reset_dark", {an, seg, dp}, DARK);
        #9 reset = 1'b0;
        check_startup("restart", {4'b1011, 7'b0010000, 1'b1});
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_display_mux.md
Name: stopwatch_display_mux

Overview:
Reads the four BCD digits produced by the stopwatch counter (minutes tens/units, seconds tens/units) and drives a 4-digit, common-anode, time-multiplexed seven-segment display. It sits between the counter and the board pins. It provides coherent per-frame digit snapshots, anti-ghost blanking, and blinking of the field being adjusted.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per digit and a 250 Hz frame); legal range is 2 or more.
BLINK_DIV, 125, scan ticks per blink half-period.

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
min1  input  3  minutes tens digit (0-5 nominal)
min2  input  4  minutes units digit (0-9 nominal)
sec1  input  3  seconds tens digit (0-5 nominal)
sec2  input  4  seconds units digit (0-9 nominal)
blink_en  input  1  blink the selected field (adjust mode)
blink_sel  input  1  field to blink: 0 = seconds (sec1, sec2), 1 = minutes (min1, min2)
dp_en  input  1  light the decimal point on the min2 digit
an  output  4  anodes, active-low; an[3]=min1, an[2]=min2, an[1]=sec1, an[0]=sec2
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Reset (async, active-high):
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1.
  - Internal state: prescaler=0, idx=0, blink counter=0, blink_phase=0, shadow digits all 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - scan_tick is high during the cycle in which prescaler==REFRESH_DIV-1.
- Digit index:
  - 2-bit idx advances 0,1,2,3,0 on each scan_tick.
  - idx=0 maps to min1 / an[3]; idx=3 maps to sec2 / an[0].
- Snapshot:
  - Captured on the scan_tick edge where idx goes 3 to 0, and on the first scan_tick after reset.
  - min1 and sec1 are zero-extended to 4 bits before capture.
  - All four digits shown within one frame come from the same snapshot; input changes mid-frame do not appear until the next frame.
- Anti-ghost blanking:
  - On the clk edge that samples scan_tick: an <= 4'b1111, seg <= 7'b1111111, dp <= 1.
  - On the following edge (the drive edge): an <= one-cold of the new idx, seg <= decode(shadow[idx]), dp <= ~(dp_en && idx==1).
  - The drive values are held until the next scan_tick.
  - Each digit is therefore lit for REFRESH_DIV-1 cycles and dark for 1 cycle.
  - All outputs are registered.
- Decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10-15 decode to a dash, 0111111.
  - Tens values 6-7 are decoded as numerals, not flagged.
- Blink:
  - The blink counter counts scan_ticks 0..BLINK_DIV-1; blink_phase toggles on each wrap.
  - Blink counting runs regardless of blink_en.
  - When blink_en && blink_phase && the digit being driven is in the field chosen by blink_sel: at the drive edge an stays 4'b1111, seg=1111111, dp=1.
  - blink_en, blink_sel and dp_en are sampled at each drive edge only; changes take effect at the next digit slot.
- Reset mid-operation: outputs go dark immediately. After release, the first digit (idx=1, from the first snapshot) is driven REFRESH_DIV+1 cycles later.
- Simultaneous events: a scan_tick coinciding with a blink_phase toggle uses the new phase for the digit driven on the next edge.

Decomposition:
- Package stopwatch_disp_pkg holds:
  - the segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - the anode constants AN_OFF and the one-cold table;
  - the digit-index type (2-bit).
- One natural combinational sub-module, seg7_decode: 4-bit digit in, 7-bit active-low segments out. It is instantiated once, on the muxed shadow digit.

Test Plan:
All scenarios use REFRESH_DIV=4, BLINK_DIV=2.
1. Reset held, then released -> an=1111, seg=1111111, dp=1 throughout reset and for 4 clk after release; first lit digit is an=1011 on the 5th edge.
2. Inputs min1=5, min2=9, sec1=3, sec2=7, dp_en=1 -> steady-state per-slot sequence:
   - an=0111, seg=0010010, dp=1
   - an=1011, seg=0010000, dp=0
   - an=1101, seg=0110000, dp=1
   - an=1110, seg=1111000, dp=1
   - exactly one cycle of an=1111 between slots.
3. Change inputs to 0,0,0,1 while idx=1 -> the remaining digits of the current frame still show 9,3,7; the next frame shows 0,0,0,1.
4. Set min2=12 -> the min2 slot shows seg=0111111 (dash); other digits are unaffected.
5. Set blink_en=1, blink_sel=1 -> min1 and min2 slots are dark (an=1111) for 2 scan ticks of each 4, and lit otherwise; seconds slots are always lit. With blink_sel=0 the roles swap.
6. Assert reset for 1 clk in the middle of a lit slot -> an=1111 the same cycle (async); after release, the timing of scenario 1 repeats exactly.
